systolic_feeder: RTL

Input-skew stage directly upstream of the 4x4 PE grid. Buffers one N x N matrix A (row operands) and one N x N matrix B (column operands). On start, streams them into the array edges with the diagonal skew the systolic dataflow needs: row i of A is delayed i cycles onto the left edge, and column j of B is delayed j cycles onto the top edge. Signals done once the last PE has finished accumulating.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_matrix_buf.sv | 35 +++
 rtl/systolic_feeder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic feeder: default sizes, FSM
// encoding, load-select codes and stream timing.
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feedState_t;

    localparam logic LOAD_SEL_A = 1'b0;
    localparam logic LOAD_SEL_B = 1'b1;

    function automatic int streamLen(input int n);
        return 2 * n - 1;
    endfunction

    localparam int STREAM_LEN = streamLen(DEF_N);
    localparam int DRAIN_LEN  = DEF_N;

endpackage

// File: rtl/systolic_matrix_buf.sv
// N x N element register file with a whole-row write port. The read view
// already includes a write landing on the current edge.
module systolic_matrix_buf
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_we,
    input  logic [$clog2(N)-1:0]                 i_row,
    input  logic [N-1:0][DATA_WIDTH-1:0]         i_data,
    output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]  o_mat
);

    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] r_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_row] <= i_data;
        end
    end

    // Write-through lets a start sampled with a load see the new row at t=0.
    always_comb begin
        o_mat = r_mem;
        if (i_we) begin
            o_mat[i_row] = i_data;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Input-skew stage for the PE grid: replays buffered matrices A and B onto the
// array edges with a one-cycle-per-row/column diagonal skew, then drains.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = DEF_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    load_sel,
    input  logic [$clog2(N)-1:0]    load_row,
    input  logic [N*DATA_WIDTH-1:0] load_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [N*DATA_WIDTH-1:0] left_out,
    output logic [N*DATA_WIDTH-1:0] top_out
);

    localparam int IDX_W      = $clog2(N);
    localparam int STREAM_CYC = streamLen(N);
    localparam int TOTAL_CYC  = STREAM_CYC + N;
    localparam int T_W        = $clog2(TOTAL_CYC);

    feedState_t r_state, w_stateNext;
    logic [T_W-1:0] r_t, w_tNext;
    logic r_done, w_doneNext;
    logic [N-1:0][DATA_WIDTH-1:0] r_left, r_top, w_leftNext, w_topNext;
    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] w_matA, w_matB;
    logic w_loadFire;

    assign load_ready = (r_state == IDLE);
    assign w_loadFire = load_valid && load_ready;

    systolic_matrix_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_bufA (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_loadFire && (load_sel == LOAD_SEL_A)),
        .i_row  (load_row),
        .i_data (load_data),
        .o_mat  (w_matA)
    );

    systolic_matrix_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_bufB (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_loadFire && (load_sel == LOAD_SEL_B)),
        .i_row  (load_row),
        .i_data (load_data),
        .o_mat  (w_matB)
    );

    // Outputs are precomputed for the cycle being entered, so they register
    // alongside the state that owns them.
    always_comb begin
        int k;
        w_stateNext = r_state;
        w_tNext     = r_t;
        w_doneNext  = 1'b0;
        w_leftNext  = '0;
        w_topNext   = '0;
        k           = 0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = STREAM;
                    w_tNext     = '0;
                end
            end
            STREAM: begin
                w_tNext = r_t + 1'b1;
                if (r_t == T_W'(STREAM_CYC - 1)) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (r_t == T_W'(TOTAL_CYC - 1)) begin
                    w_stateNext = IDLE;
                    w_doneNext  = 1'b1;
                    w_tNext     = '0;
                end else begin
                    w_tNext = r_t + 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_tNext     = '0;
            end
        endcase
        if (w_stateNext == STREAM) begin
            for (int i = 0; i < N; i++) begin
                k = int'(w_tNext) - i;
                if (k >= 0 && k < N) begin
                    w_leftNext[IDX_W'(i)] = w_matA[IDX_W'(i)][IDX_W'(k)];
                    w_topNext[IDX_W'(i)]  = w_matB[IDX_W'(k)][IDX_W'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_done  <= 1'b0;
            r_left  <= '0;
            r_top   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_t     <= w_tNext;
            r_done  <= w_doneNext;
            r_left  <= w_leftNext;
            r_top   <= w_topNext;
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign left_out = r_left;
    assign top_out  = r_top;

endmodule
